// File: rtl/multicycle_controller.sv
// Multi-cycle sequencing FSM for the RV32I-subset core.
// Drives PC/IR/memory/ALU/regfile controls per state from op, f3, zero, sign_bit.
//
// Ports:
//   clk, rst               clock (rising edge), async active-high reset
//   op[6:0], f3[2:0]       opcode and funct3 from the IR
//   zero, sign_bit         ALU result flags, used only in BRANCH
//   pc_write, pc_src       PC load enable and source select
//   adr_src, mem_write     memory address select and write enable
//   ir_write, reg_write    IR/old-PC load and register file write enables
//   result_src             write-back value select
//   alu_src_a, alu_src_b   ALU operand selects
//   alu_ctrl, imm_sel      ALU operation and immediate format
//   state                  current state, for debug
module multicycle_controller #(
   parameter logic [6:0] OP_R    = 7'd0,
   parameter logic [6:0] OP_LW   = 7'd1,
   parameter logic [6:0] OP_ADDI = 7'd2,
   parameter logic [6:0] OP_XORI = 7'd3,
   parameter logic [6:0] OP_ORI  = 7'd4,
   parameter logic [6:0] OP_SLTI = 7'd5,
   parameter logic [6:0] OP_JALR = 7'd6,
   parameter logic [6:0] OP_SW   = 7'd7,
   parameter logic [6:0] OP_JAL  = 7'd8,
   parameter logic [6:0] OP_BEQ  = 7'd9,
   parameter logic [6:0] OP_BNE  = 7'd10,
   parameter logic [6:0] OP_BLT  = 7'd11,
   parameter logic [6:0] OP_BGE  = 7'd12,
   parameter logic [6:0] OP_LUI  = 7'd13
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic [2:0] f3,
   input  logic       zero,
   input  logic       sign_bit,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic       adr_src,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_ctrl,
   output logic [2:0] imm_sel,
   output logic [3:0] state
);

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEM_ADR = 4'd2,
      S_MEM_RD  = 4'd3,
      S_MEM_WB  = 4'd4,
      S_MEM_WR  = 4'd5,
      S_EXEC_R  = 4'd6,
      S_EXEC_I  = 4'd7,
      S_ALU_WB  = 4'd8,
      S_BRANCH  = 4'd9,
      S_JAL     = 4'd10,
      S_JALR1   = 4'd11,
      S_JALR2   = 4'd12,
      S_LUI     = 4'd13
   } state_t;

   state_t state_q;
   state_t state_d;

   logic pc_write_raw;
   logic mem_write_raw;
   logic ir_write_raw;
   logic reg_write_raw;
   logic br_taken;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_FETCH;
      else     state_q <= state_d;
   end

   always_comb begin
      imm_sel = 3'b000;
      case (op)
         OP_SW:  imm_sel = 3'b001;
         OP_BEQ, OP_BNE, OP_BLT, OP_BGE:
                 imm_sel = 3'b010;
         OP_JAL: imm_sel = 3'b011;
         OP_LUI: imm_sel = 3'b100;
         default: imm_sel = 3'b000;
      endcase
   end

   always_comb begin
      br_taken = 1'b0;
      case (op)
         OP_BEQ: br_taken = zero;
         OP_BNE: br_taken = ~zero;
         OP_BLT: br_taken = sign_bit;
         OP_BGE: br_taken = ~sign_bit;
         default: br_taken = 1'b0;
      endcase
   end

   always_comb begin
      state_d       = S_FETCH;
      pc_write_raw  = 1'b0;
      pc_src        = 2'b00;
      adr_src       = 1'b0;
      mem_write_raw = 1'b0;
      ir_write_raw  = 1'b0;
      reg_write_raw = 1'b0;
      result_src    = 2'b00;
      alu_src_a     = 2'b00;
      alu_src_b     = 2'b00;
      alu_ctrl      = ALU_ADD;
      case (state_q)
         S_FETCH: begin
            ir_write_raw = 1'b1;
            alu_src_b    = 2'b10;
            pc_write_raw = 1'b1;
            state_d      = S_DECODE;
         end
         S_DECODE: begin
            // old-PC + imm lands in ALUOut as the branch/JAL target
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            case (op)
               OP_LW, OP_SW: state_d = S_MEM_ADR;
               OP_R:         state_d = S_EXEC_R;
               OP_ADDI, OP_XORI, OP_ORI, OP_SLTI:
                             state_d = S_EXEC_I;
               OP_BEQ, OP_BNE, OP_BLT, OP_BGE:
                             state_d = S_BRANCH;
               OP_JAL:       state_d = S_JAL;
               OP_JALR:      state_d = S_JALR1;
               OP_LUI:       state_d = S_LUI;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEM_ADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            if (op == OP_LW)      state_d = S_MEM_RD;
            else if (op == OP_SW) state_d = S_MEM_WR;
            else                  state_d = S_FETCH;
         end
         S_MEM_RD: begin
            adr_src = 1'b1;
            state_d = S_MEM_WB;
         end
         S_MEM_WB: begin
            reg_write_raw = 1'b1;
            result_src    = 2'b01;
         end
         S_MEM_WR: begin
            adr_src       = 1'b1;
            mem_write_raw = 1'b1;
         end
         S_EXEC_R: begin
            alu_src_a = 2'b10;
            alu_ctrl  = f3;
            state_d   = S_ALU_WB;
         end
         S_EXEC_I: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            case (op)
               OP_XORI: alu_ctrl = ALU_XOR;
               OP_ORI:  alu_ctrl = ALU_OR;
               OP_SLTI: alu_ctrl = ALU_SLT;
               default: alu_ctrl = ALU_ADD;
            endcase
            state_d = S_ALU_WB;
         end
         S_ALU_WB: begin
            reg_write_raw = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a    = 2'b10;
            alu_ctrl     = ALU_SUB;
            pc_src       = 2'b01;
            pc_write_raw = br_taken;
         end
         S_JAL, S_JALR2: begin
            // link value old-PC + 4 written back while PC takes ALUOut
            alu_src_a     = 2'b01;
            alu_src_b     = 2'b10;
            result_src    = 2'b10;
            reg_write_raw = 1'b1;
            pc_write_raw  = 1'b1;
            pc_src        = 2'b01;
         end
         S_JALR1: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            state_d   = S_JALR2;
         end
         S_LUI: begin
            result_src    = 2'b11;
            reg_write_raw = 1'b1;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   // reset holds FETCH outputs but must never write anything
   assign pc_write  = pc_write_raw  & ~rst;
   assign mem_write = mem_write_raw & ~rst;
   assign ir_write  = ir_write_raw  & ~rst;
   assign reg_write = reg_write_raw & ~rst;
   assign state     = state_q;

endmodule
